// File: rtl/seq_detector_param.sv
// ----------------------------------------------------------------------------
// seq_detector_param
//
// Serial sequence detector with a runtime-loadable pattern of 1..PAT_W bits.
// Bits on x are sampled on rising clk edges where valid=1 and shifted into a
// history register. A match fires when the newest len bits equal the low len
// bits of the active pattern. pattern[len-1] is the oldest (first received)
// bit of the window. Overlapping or non-overlapping detection is chosen when
// the configuration is loaded.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous, active-low reset
//   x          serial data bit
//   valid      x is sampled only when valid=1
//   cfg_load   one-cycle pulse: latch pattern/pat_len/overlap, flush history
//   pattern    pattern to latch (PAT_W bits)
//   pat_len    pattern length to latch (0 or >PAT_W means PAT_W)
//   overlap    overlap mode to latch (1 = overlapping)
//   clr_cnt    synchronous clear of match_cnt (wins over a same-cycle match)
//   z          registered single-cycle match pulse
//   match_cnt  saturating count of matches
//   armed      history holds at least a full window of the active length
// ----------------------------------------------------------------------------
module seq_detector_param #(
    parameter int                 PAT_W   = 8,
    parameter int                 CNT_W   = 8,
    parameter logic [PAT_W-1:0]   DEF_PAT = PAT_W'(8'h0A),
    parameter int                 DEF_LEN = 4,
    parameter bit                 DEF_OVL = 1'b0,
    localparam int                LEN_W   = $clog2(PAT_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              x,
    input  logic              valid,
    input  logic              cfg_load,
    input  logic [PAT_W-1:0]  pattern,
    input  logic [LEN_W-1:0]  pat_len,
    input  logic              overlap,
    input  logic              clr_cnt,
    output logic              z,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              armed
);

    localparam logic [LEN_W-1:0] PAT_W_L   = LEN_W'(PAT_W);
    // The reset length obeys the same clamp rule as a loaded length.
    localparam logic [LEN_W-1:0] DEF_LEN_L =
        (DEF_LEN < 1 || DEF_LEN > PAT_W) ? PAT_W_L : LEN_W'(DEF_LEN);

    // Active configuration
    logic [PAT_W-1:0] pat_reg, pat_next;
    logic [LEN_W-1:0] len_reg, len_next;
    logic             ovl_reg, ovl_next;

    // Stream state
    logic [PAT_W-1:0] hist_reg, hist_next;
    logic [LEN_W-1:0] fill_reg, fill_next;

    // Output registers
    logic             z_reg, z_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             armed_reg, armed_next;

    // Helpers
    logic [PAT_W-1:0] hist_shift;
    logic [LEN_W-1:0] fill_inc;
    logic [LEN_W-1:0] len_in;
    logic [PAT_W-1:0] bit_ok;
    logic             window_hit;
    logic             match;

    assign hist_shift = {hist_reg[PAT_W-2:0], x};

    // Per-bit masked compare: bits at or above the active length are ignored.
    generate
        for (genvar gi = 0; gi < PAT_W; gi++) begin : g_cmp
            assign bit_ok[gi] = (LEN_W'(gi) >= len_reg) ||
                                (hist_shift[gi] == pat_reg[gi]);
        end
    endgenerate

    assign window_hit = &bit_ok;

    always_comb begin
        fill_inc = (fill_reg >= PAT_W_L) ? PAT_W_L : fill_reg + LEN_W'(1);
        len_in   = (pat_len == '0 || pat_len > PAT_W_L) ? PAT_W_L : pat_len;

        // A sample arriving with cfg_load is discarded, so it cannot match.
        match = valid && !cfg_load && (fill_inc >= len_reg) && window_hit;

        pat_next  = pat_reg;
        len_next  = len_reg;
        ovl_next  = ovl_reg;
        hist_next = hist_reg;
        fill_next = fill_reg;

        if (cfg_load) begin
            pat_next  = pattern;
            len_next  = len_in;
            ovl_next  = overlap;
            hist_next = '0;
            fill_next = '0;
        end else if (valid) begin
            hist_next = hist_shift;
            // Non-overlap restarts the window count so the next match needs
            // len fresh bits; overlap keeps it so a suffix can seed a match.
            fill_next = (match && !ovl_reg) ? '0 : fill_inc;
        end

        z_next     = match;
        armed_next = (fill_next >= len_next);

        cnt_next = cnt_reg;
        if (clr_cnt)
            cnt_next = '0;
        else if (match && cnt_reg != '1)
            cnt_next = cnt_reg + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_reg   <= DEF_PAT;
            len_reg   <= DEF_LEN_L;
            ovl_reg   <= DEF_OVL;
            hist_reg  <= '0;
            fill_reg  <= '0;
            z_reg     <= 1'b0;
            cnt_reg   <= '0;
            armed_reg <= 1'b0;
        end else begin
            pat_reg   <= pat_next;
            len_reg   <= len_next;
            ovl_reg   <= ovl_next;
            hist_reg  <= hist_next;
            fill_reg  <= fill_next;
            z_reg     <= z_next;
            cnt_reg   <= cnt_next;
            armed_reg <= armed_next;
        end
    end

    assign z         = z_reg;
    assign match_cnt = cnt_reg;
    assign armed     = armed_reg;

endmodule

// File: tb/tb_seq_detector_param.sv
// ----------------------------------------------------------------------------
// tb_seq_detector_param
//
// Directed bench for seq_detector_param (PAT_W=8, CNT_W=2). The driver applies
// one input vector per cycle on the falling edge and pushes the hand-computed
// response expected after the next rising edge into a queue; a monitor pops
// and compares one entry per cycle, 1 time unit after the rising edge.
// ----------------------------------------------------------------------------
module tb_seq_detector_param;

    localparam int PAT_W = 8;
    localparam int CNT_W = 2;
    localparam int LEN_W = $clog2(PAT_W + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              x = 1'b0;
    logic              valid = 1'b0;
    logic              cfg_load = 1'b0;
    logic [PAT_W-1:0]  pattern = '0;
    logic [LEN_W-1:0]  pat_len = '0;
    logic              overlap = 1'b0;
    logic              clr_cnt = 1'b0;
    logic              z;
    logic [CNT_W-1:0]  match_cnt;
    logic              armed;

    seq_detector_param #(
        .PAT_W(PAT_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .x(x),
        .valid(valid),
        .cfg_load(cfg_load),
        .pattern(pattern),
        .pat_len(pat_len),
        .overlap(overlap),
        .clr_cnt(clr_cnt),
        .z(z),
        .match_cnt(match_cnt),
        .armed(armed)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        logic  ez;
        int    ecnt;
        int    earm;   // -1: not checked
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Apply one vector at the falling edge and queue its expected response.
    task automatic step(input string name, input logic rn, input logic v,
                        input logic xb, input logic cl, input logic clr,
                        input logic ez, input int ecnt, input int earm);
        exp_t e;
        @(negedge clk);
        rst_n    = rn;
        valid    = v;
        x        = xb;
        cfg_load = cl;
        clr_cnt  = clr;
        e.name = name;
        e.ez   = ez;
        e.ecnt = ecnt;
        e.earm = earm;
        exp_q.push_back(e);
    endtask

    task automatic set_cfg(input logic [PAT_W-1:0] p, input int len, input logic ovl);
        pattern = p;
        pat_len = LEN_W'(len);
        overlap = ovl;
    endtask

    // Monitor: one compare per queued cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (z !== e.ez || match_cnt !== CNT_W'(e.ecnt) ||
                    (e.earm >= 0 && armed !== e.earm[0])) begin
                    n_fail++;
                    $display("FAIL %s: got z=%b cnt=%0d armed=%b, want z=%b cnt=%0d armed=%0d",
                             e.name, z, match_cnt, armed, e.ez, e.ecnt, e.earm);
                end else begin
                    $display("ok   %s: z=%b cnt=%0d armed=%b", e.name, z, match_cnt, armed);
                end
            end
        end
    end

    initial begin
        // Reset held: all outputs at reset values
        step("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        step("reset", 0, 0, 0, 0, 0, 0, 0, 0);

        // Non-overlap default 1010: one pulse after the 4th bit
        step("no1",   1, 1, 1, 0, 0, 0, 0, 0);
        step("no2",   1, 1, 0, 0, 0, 0, 0, 0);
        step("no3",   1, 1, 1, 0, 0, 0, 0, 0);
        step("no4",   1, 1, 0, 0, 0, 1, 1, 0);
        step("no5",   1, 1, 1, 0, 0, 0, 1, 0);
        step("no6",   1, 1, 0, 0, 0, 0, 1, 0);
        step("noidl", 1, 0, 0, 0, 0, 0, 1, 0);

        // Overlap 1010: pulses after the 4th and 6th bits
        set_cfg(8'h0A, 4, 1'b1);
        step("ovload", 1, 0, 0, 1, 1, 0, 0, 0);
        step("ov1",   1, 1, 1, 0, 0, 0, 0, 0);
        step("ov2",   1, 1, 0, 0, 0, 0, 0, 0);
        step("ov3",   1, 1, 1, 0, 0, 0, 0, 0);
        step("ov4",   1, 1, 0, 0, 0, 1, 1, 1);
        step("ov5",   1, 1, 1, 0, 0, 0, 1, -1);
        step("ov6",   1, 1, 0, 0, 0, 1, 2, -1);
        step("ovidl", 1, 0, 0, 0, 0, 0, 2, -1);

        // Pattern 110, len 3, with idle cycles between bits
        set_cfg(8'h06, 3, 1'b0);
        step("gpload", 1, 0, 0, 1, 1, 0, 0, 0);
        step("gp1",    1, 1, 1, 0, 0, 0, 0, 0);
        step("gpidl",  1, 0, 0, 0, 0, 0, 0, 0);
        step("gpidl",  1, 0, 1, 0, 0, 0, 0, 0);
        step("gp2",    1, 1, 1, 0, 0, 0, 0, 0);
        step("gpidl",  1, 0, 0, 0, 0, 0, 0, 0);
        step("gpidl",  1, 0, 0, 0, 0, 0, 0, 0);
        step("gp3",    1, 1, 0, 0, 0, 1, 1, 0);
        step("gpidl",  1, 0, 0, 0, 0, 0, 1, 0);

        // Pattern 11 overlap: consecutive matches, saturation at 3, clear wins
        set_cfg(8'h03, 2, 1'b1);
        step("stload", 1, 0, 0, 1, 1, 0, 0, 0);
        step("st1",    1, 1, 1, 0, 0, 0, 0, 0);
        step("st2",    1, 1, 1, 0, 0, 1, 1, 1);
        step("st3",    1, 1, 1, 0, 0, 1, 2, -1);
        step("st4",    1, 1, 1, 0, 0, 1, 3, -1);
        step("st5",    1, 1, 1, 0, 0, 1, 3, -1);
        step("st6",    1, 1, 1, 0, 0, 1, 3, -1);
        step("st7",    1, 1, 1, 0, 0, 1, 3, -1);
        step("stclr",  1, 1, 1, 0, 1, 1, 0, -1);
        step("stidl",  1, 0, 0, 0, 0, 0, 0, -1);

        // cfg_load colliding with a completing bit; pat_len=0 clamps to 8
        set_cfg(8'h0A, 4, 1'b0);
        step("ccload", 1, 0, 0, 1, 0, 0, 0, 0);
        step("cc1",    1, 1, 1, 0, 0, 0, 0, 0);
        step("cc2",    1, 1, 0, 0, 0, 0, 0, 0);
        step("cc3",    1, 1, 1, 0, 0, 0, 0, 0);
        set_cfg(8'hAA, 0, 1'b0);
        step("cccoll", 1, 1, 0, 1, 0, 0, 0, 0);
        // 10101010 with len 8: a 4-bit window would already hit at bit 4
        for (int i = 0; i < 8; i++) begin
            logic bitv;
            bitv = (i % 2 == 0);
            if (i < 7)
                step("cclen", 1, 1, bitv, 0, 0, 0, 0, 0);
            else
                step("cclen8", 1, 1, bitv, 0, 0, 1, 1, 0);
        end

        // Reset mid-stream after 101: the trailing 0 must not match
        set_cfg(8'h0A, 4, 1'b0);
        step("rsload", 1, 0, 0, 1, 0, 0, 1, 0);
        step("rs1",    1, 1, 1, 0, 0, 0, 1, 0);
        step("rs2",    1, 1, 0, 0, 0, 0, 1, 0);
        step("rs3",    1, 1, 1, 0, 0, 0, 1, 0);
        step("rsasrt", 0, 0, 0, 0, 0, 0, 0, 0);
        step("rsasrt", 0, 0, 0, 0, 0, 0, 0, 0);
        step("rs4",    1, 1, 0, 0, 0, 0, 0, 0);
        step("rsidl",  1, 0, 0, 0, 0, 0, 0, 0);

        // Drain with a bounded wait
        begin
            int guard = 0;
            while (exp_q.size() > 0 && guard < 20) begin
                @(posedge clk);
                guard++;
            end
            @(negedge clk);
            if (exp_q.size() > 0) begin
                n_fail++;
                $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
